picorv32_mem_arbiter: RTL and testbench

- Shares one synchronous single-port word SRAM between two picorv32 native-interface masters: m0 is the CPU, m1 is an auxiliary master such as a loader or DMA.
- Decodes a console address and routes byte writes to a backpressured console sink.
- Sits between the core(s) and the on-chip memory in simulation and FPGA tops.

---
 rtl/picorv32_mem_arbiter_pkg.sv | 13 +
 rtl/picorv32_rr_arbiter.sv | 39 +++
 rtl/picorv32_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_mem_arbiter_pkg.sv
// rtl/picorv32_mem_arbiter_pkg.sv - shared state encoding and constants for the memory arbiter
package picorv32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_CON  = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  localparam logic [31:0] CON_ADDR_DEFAULT = 32'h1000_0000;

endpackage

// File: rtl/picorv32_rr_arbiter.sv
// rtl/picorv32_rr_arbiter.sv - two-requester grant selector; PICORV32_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module picorv32_rr_arbiter (
  input  logic clk,
  input  logic resetn,
  input  logic req0_i,
  input  logic req1_i,
  input  logic advance_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  assign gnt_valid_o = req0_i | req1_i;

`ifdef PICORV32_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie the master not granted last wins; the reset value makes m0 win first.
  always_comb begin
    if (req0_i && req1_i) gnt_idx_o = ~last_q;
    else                  gnt_idx_o = req1_i;
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && gnt_valid_o) last_d = gnt_idx_o;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  logic unused_rr;

  assign gnt_idx_o = ~req0_i & req1_i;
  assign unused_rr = &{1'b0, clk, resetn, advance_i};
`endif

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-master SRAM/console arbiter; PICORV32_ARB_ROUND_ROBIN_EN enables round-robin ties
module picorv32_mem_arbiter
  import picorv32_mem_arbiter_pkg::*;
#(
  parameter int          MEM_WORDS = 16384,
  parameter int          AW        = 14,
  parameter logic [31:0] CON_ADDR  = CON_ADDR_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m0_valid,
  input  logic          m0_instr,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic          m1_instr,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          con_valid,
  output logic [7:0]    con_data,
  input  logic          con_ready,
  output logic          bus_err,
  output logic          grant
);

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;
  logic [1:0]    ready_q, ready_d;
  logic          rd_q, rd_d;
  logic          sram_en_q, sram_en_d;
  logic [3:0]    sram_we_q, sram_we_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;
  logic          con_valid_q, con_valid_d;
  logic [7:0]    con_data_q, con_data_d;
  logic          bus_err_q, bus_err_d;

  logic          gnt_valid, gnt_idx;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          is_con, is_mem;
  logic [1:0]    win_onehot, cur_onehot;
  logic          unused_instr;

  assign unused_instr = &{1'b0, m0_instr, m1_instr};

  picorv32_rr_arbiter u_rr (
    .clk         (clk),
    .resetn      (resetn),
    .req0_i      (m0_valid),
    .req1_i      (m1_valid),
    .advance_i   (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign sel_addr   = gnt_idx ? m1_addr  : m0_addr;
  assign sel_wdata  = gnt_idx ? m1_wdata : m0_wdata;
  assign sel_wstrb  = gnt_idx ? m1_wstrb : m0_wstrb;
  assign is_con     = (sel_addr == CON_ADDR);
  assign is_mem     = (sel_addr[31:2] < MEM_LIMIT);
  assign win_onehot = gnt_idx ? 2'b10 : 2'b01;
  assign cur_onehot = grant_q ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          if (is_con)      state_d = (sel_wstrb != 4'd0) ? ST_CON : ST_RESP;
          else if (is_mem) state_d = ST_MEM;
          else             state_d = ST_RESP;
        end
      end
      ST_MEM:  state_d = ST_RESP;
      ST_CON:  if (con_ready) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for every registered output; ready is raised on the edge that enters RESP.
  always_comb begin
    grant_d      = grant_q;
    ready_d      = 2'b00;
    rd_d         = rd_q;
    sram_en_d    = 1'b0;
    sram_we_d    = 4'd0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    con_valid_d  = con_valid_q;
    con_data_d   = con_data_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant_d = gnt_idx;
          rd_d    = 1'b0;
          if (is_con) begin
            if (sel_wstrb != 4'd0) begin
              con_valid_d = 1'b1;
              con_data_d  = sel_wdata[7:0];
            end else begin
              ready_d = win_onehot;
            end
          end else if (is_mem) begin
            sram_en_d    = 1'b1;
            sram_we_d    = sel_wstrb;
            sram_addr_d  = sel_addr[AW+1:2];
            sram_wdata_d = sel_wdata;
            rd_d         = (sel_wstrb == 4'd0);
          end else begin
            bus_err_d = 1'b1;
            ready_d   = win_onehot;
          end
        end
      end
      ST_MEM: ready_d = cur_onehot;
      ST_CON: begin
        if (con_ready) begin
          con_valid_d = 1'b0;
          ready_d     = cur_onehot;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q      <= 1'b0;
      ready_q      <= 2'b00;
      rd_q         <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 4'd0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'd0;
      con_valid_q  <= 1'b0;
      con_data_q   <= 8'd0;
      bus_err_q    <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      ready_q      <= ready_d;
      rd_q         <= rd_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      con_valid_q  <= con_valid_d;
      con_data_q   <= con_data_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // SRAM read data arrives in the RESP cycle, so it is steered combinationally.
  assign m0_ready   = ready_q[0];
  assign m1_ready   = ready_q[1];
  assign m0_rdata   = (ready_q[0] && rd_q) ? sram_rdata : 32'd0;
  assign m1_rdata   = (ready_q[1] && rd_q) ? sram_rdata : 32'd0;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign con_valid  = con_valid_q;
  assign con_data   = con_data_q;
  assign bus_err    = bus_err_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - self-checking bench for picorv32_mem_arbiter with a transaction-level reference model
module tb_picorv32_mem_arbiter;

  localparam int          MW  = 16384;
  localparam logic [31:0] CON = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        con_valid, con_ready, bus_err, grant;
  logic [7:0]  con_data;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sram [0:MW-1];
  logic [31:0] ref_mem [0:MW-1];
  logic        ref_err;
  int          ref_last;
  logic [31:0] last_rdata;

  picorv32_mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .bus_err(bus_err), .grant(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= sram[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {57'd0, m0_ready, m1_ready, sram_en, con_valid, bus_err, grant, |sram_we}, 64'd0);
    check({tag, "_dat"}, {10'd0, sram_addr, con_data, sram_wdata}, 64'd0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'd0);
  endtask

  task automatic set_master(input int m, input logic v, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    if (m == 0) begin m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
    else        begin m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
  endtask

  // One master alone; expectations come from the address map and the reference memory.
  task automatic run_req(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int con_delay);
    logic is_con, is_mem, con_wr, done, seen_en, seen_con, other_bad, rdy;
    logic [31:0] exp_rdata, obs_rdata;
    int exp_lat, cyc, held;
    is_con    = (addr == CON);
    is_mem    = !is_con && ((addr >> 2) < MW);
    con_wr    = is_con && (wstrb != 4'd0);
    exp_lat   = con_wr ? con_delay + 2 : (is_mem ? 2 : 1);
    exp_rdata = (is_mem && wstrb == 4'd0) ? ref_mem[addr >> 2] : 32'd0;
    if (is_mem)
      for (int b = 0; b < 4; b++) if (wstrb[b]) ref_mem[addr >> 2][8*b +: 8] = wdata[8*b +: 8];
    if (!is_con && !is_mem) ref_err = 1'b1;
    ref_last = m;
    set_master(m, 1'b1, addr, wdata, wstrb);
    cyc = 0; held = 0; done = 0; seen_en = 0; seen_con = 0; other_bad = 0; obs_rdata = 32'd0;
    while (!done && cyc < 20 + con_delay) begin
      @(posedge clk); #1; cyc++;
      if (sram_en) seen_en = 1;
      if (is_mem && cyc == 1) begin
        check("mem_strobe", {sram_en, sram_we, 18'(sram_addr)}, {1'b1, wstrb, 18'(addr[15:2])});
        if (wstrb != 4'd0) check("mem_wdata", sram_wdata, wdata);
      end
      if (con_valid) begin
        seen_con = 1;
        if (!con_ready) begin
          check("con_data_hold", con_data, wdata[7:0]);
          if (held == con_delay) con_ready = 1'b1;
          else held++;
        end
      end
      rdy = (m == 0) ? m0_ready : m1_ready;
      if ((m == 0) ? (m1_ready || m1_rdata != 0) : (m0_ready || m0_rdata != 0)) other_bad = 1;
      if (rdy) begin
        done = 1;
        obs_rdata = (m == 0) ? m0_rdata : m1_rdata;
        check("resp_grant", grant, m[0]);
        check("resp_bus_err", bus_err, ref_err);
      end
    end
    check("resp_seen", done, 1);
    check("resp_latency", cyc, exp_lat);
    check("resp_rdata", obs_rdata, exp_rdata);
    check("sram_en_used", seen_en, is_mem);
    check("con_used", seen_con, con_wr);
    check("other_quiet", other_bad, 0);
    last_rdata = obs_rdata;
    set_master(m, 1'b0, 32'd0, 32'd0, 4'd0);
    con_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // Both masters read in the same cycle; the model picks the tie winner.
  task automatic run_dual(input logic [31:0] a0, input logic [31:0] a1);
    int w, l, cyc;
    logic [31:0] e0, e1;
`ifdef PICORV32_ARB_ROUND_ROBIN_EN
    w = (ref_last == 0) ? 1 : 0;
`else
    w = 0;
`endif
    l = 1 - w;
    e0 = ref_mem[a0 >> 2];
    e1 = ref_mem[a1 >> 2];
    set_master(0, 1'b1, a0, 32'd0, 4'd0);
    set_master(1, 1'b1, a1, 32'd0, 4'd0);
    cyc = 0;
    while (!(m0_ready || m1_ready) && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check("dual_first", {m1_ready, m0_ready}, (w == 1) ? 2'b10 : 2'b01);
    check("dual_first_lat", cyc, 2);
    check("dual_first_rdata", (w == 1) ? m1_rdata : m0_rdata, (w == 1) ? e1 : e0);
    set_master(w, 1'b0, 32'd0, 32'd0, 4'd0);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end
    while (!((l == 1) ? m1_ready : m0_ready) && cyc < 10);
    check("dual_second", {m1_ready, m0_ready}, (l == 1) ? 2'b10 : 2'b01);
    check("dual_second_grant", grant, l[0]);
    check("dual_second_rdata", (l == 1) ? m1_rdata : m0_rdata, (l == 1) ? e1 : e0);
    ref_last = l;
    set_master(l, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return CON;
      1:       return (MW - 1) * 4 + $urandom_range(0, 3);
      2:       return MW * 4 + $urandom_range(0, 255) * 4;
      3:       return $urandom;
      default: return $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    int cyc;
    for (int i = 0; i < MW; i++) begin sram[i] = 32'd0; ref_mem[i] = 32'd0; end
    sram_rdata = 32'd0;
    resetn = 1'b0; con_ready = 1'b0; m0_instr = 1'b0; m1_instr = 1'b0;
    set_master(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_master(1, 1'b0, 32'd0, 32'd0, 4'd0);
    ref_err = 1'b0; ref_last = 1; last_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;

    run_req(0, 32'h100, 32'hDEADBEEF, 4'hF, 0);
    run_req(0, 32'h100, 32'd0, 4'h0, 0);
    check("readback_deadbeef", last_rdata, 32'hDEADBEEF);

    ref_mem[32'h200 >> 2] = 32'hA5A5_0001; sram[32'h200 >> 2] = 32'hA5A5_0001;
    ref_mem[32'h204 >> 2] = 32'h5A5A_0002; sram[32'h204 >> 2] = 32'h5A5A_0002;
    run_dual(32'h200, 32'h204);
    run_dual(32'h200, 32'h204);

    // m1 console write stalls 5 cycles while m0 waits behind it.
    set_master(1, 1'b1, CON, 32'h0000_0041, 4'h1);
    @(posedge clk); #1;
    set_master(0, 1'b1, 32'h100, 32'd0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      check("stall_con", {con_valid, con_data, m0_ready, m1_ready}, {1'b1, 8'h41, 2'b00});
      @(posedge clk); #1;
    end
    con_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {m1_ready, m0_ready, con_valid}, 3'b100);
    set_master(1, 1'b0, 32'd0, 32'd0, 4'd0);
    con_ready = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!m0_ready && cyc < 10);
    check("blocked_m0_served", {m0_ready, m0_rdata}, {1'b1, 32'hDEADBEEF});
    set_master(0, 1'b0, 32'd0, 32'd0, 4'd0);
    ref_last = 0;
    @(posedge clk); #1;

    run_req(0, 32'h104, 32'h1122_3344, 4'hF, 0);
    run_req(0, 32'h104, 32'h0000_AB00, 4'b0010, 0);
    run_req(1, 32'h104, 32'd0, 4'h0, 0);
    check("byte_merge", last_rdata, 32'h1122_AB44);

    run_req(0, 32'h0002_0000, 32'h1234_5678, 4'h0, 0);
    repeat (3) @(posedge clk);
    #1 check("bus_err_sticky", bus_err, 1'b1);
    run_req(1, CON, 32'd0, 4'h0, 0);

    // Reset in the middle of a console write.
    set_master(0, 1'b1, CON, 32'h0000_005A, 4'h1);
    @(posedge clk); #1;
    check("pre_reset_con", {con_valid, con_data}, {1'b1, 8'h5A});
    resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    set_master(0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1; resetn = 1'b1;
    ref_err = 1'b0; ref_last = 1;
    @(posedge clk); #1;
    run_req(0, 32'h100, 32'd0, 4'h0, 0);
    check("post_reset_read", last_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0)
        run_dual($urandom_range(0, 63) * 4, $urandom_range(0, 63) * 4);
      else
        run_req($urandom_range(0, 1), rand_addr(), $urandom,
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
